gpu_mem_controller: RTL and testbench
=====================================

Name: gpu_mem_controller

Overview:
- Arbiter/relay sitting directly upstream of the external memory model.
- Many memory consumers (per-thread LSUs or fetchers) request service. The block multiplexes them onto NUM_CHANNELS memory channels.
- Each channel runs its own FSM: capture a consumer request, issue it downstream, wait for completion, relay the result back.
- One instance is used for data memory (writes enabled) and one for program memory (WRITE_ENABLE=0).

Parameters:
- ADDR_WIDTH, 8, address width on both sides.
- DATA_WIDTH, 8, data width on both sides.
- NUM_CONSUMERS, 8, number of requesting consumers.
- NUM_CHANNELS, 4, downstream memory channels; must be ≤ NUM_CONSUMERS.
- WRITE_ENABLE, 1, 0 removes write logic; write outputs are tied to 0 and consumer writes are ignored.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- consumer_read_valid  in  [NUM_CONSUMERS]  read request, held until ready.
- consumer_read_addr  in  ADDR_WIDTH x NUM_CONSUMERS  read address.
- consumer_read_ready  out  [NUM_CONSUMERS]  read done; data valid while high.
- consumer_read_data  out  DATA_WIDTH x NUM_CONSUMERS  returned read data.
- consumer_write_valid  in  [NUM_CONSUMERS]  write request, held until ready.
- consumer_write_addr  in  ADDR_WIDTH x NUM_CONSUMERS  write address.
- consumer_write_data  in  DATA_WIDTH x NUM_CONSUMERS  write data.
- consumer_write_ready  out  [NUM_CONSUMERS]  write done.
- mem_read_valid  out  [NUM_CHANNELS]  one-cycle read issue pulse.
- mem_read_addr  out  ADDR_WIDTH x NUM_CHANNELS  read address.
- mem_read_ready  in  [NUM_CHANNELS]  one-cycle completion pulse.
- mem_read_data  in  DATA_WIDTH x NUM_CHANNELS  data, valid with mem_read_ready.
- mem_write_valid  out  [NUM_CHANNELS]  one-cycle write issue pulse.
- mem_write_addr  out  ADDR_WIDTH x NUM_CHANNELS  write address.
- mem_write_data  out  DATA_WIDTH x NUM_CHANNELS  write data.
- mem_write_ready  in  [NUM_CHANNELS]  one-cycle completion pulse.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: every output is 0; all channel FSMs are IDLE; claimed mask is 0; each channel's owner index is 0.
- Registered outputs: all outputs are registered; there are no combinational in-to-out paths.
- Per-channel FSM: IDLE -> READ_WAIT | WRITE_WAIT -> RELAY -> IDLE.
- IDLE:
  - The channel scans consumers from 0 upward and takes the first unclaimed consumer with valid set.
  - Read beats write for the same consumer.
  - On the grab edge: set claimed[c], latch the owner index, drive mem_*_addr (and data for writes), and set mem_*_valid for exactly one cycle.
  - Next state is READ_WAIT or WRITE_WAIT.
- Channel evaluation order: channels are evaluated 0..NUM_CHANNELS-1 within the same cycle, using the claim mask as updated by lower channels. No two channels ever own the same consumer. Channel 0 has highest grab priority.
- READ_WAIT:
  - Waits for mem_read_ready. mem_read_valid stays 0 (no re-issue).
  - On ready: latch mem_read_data into consumer_read_data[owner], set consumer_read_ready[owner], go to RELAY.
- WRITE_WAIT: on mem_write_ready, set consumer_write_ready[owner] and go to RELAY.
- RELAY (four-phase handshake):
  - Hold ready and data until the owner's corresponding valid is sampled low.
  - On that edge: clear ready, clear claimed[owner], go to IDLE.
  - A new grab is possible on the following edge.
- Latency: the mem valid pulse is high the cycle after consumer valid is first sampled. The consumer ready rises the cycle after the mem ready pulse.
- Unsolicited mem_*_ready (channel not in the matching WAIT state) is ignored.
- More requesters than channels: excess consumers stall, with valid held, until a channel frees. Requests are never dropped.
- A consumer dropping valid before ready is a protocol violation; its behaviour is undefined and it need not be handled.
- Address and data are passed through unchanged; there is no arithmetic.
- Reset mid-transaction: all state clears immediately. An in-flight downstream completion that arrives after reset is ignored.
- WRITE_ENABLE=0: consumer_write_valid is never granted; mem_write_* and consumer_write_ready stay 0.

Test Plan:
- Single read: consumer 0 reads addr 0x10 (memory 0x10=0xA5, READ_LATENCY=2) -> mem_read_valid[0] pulses 1 cycle with addr 0x10. Then consumer_read_ready[0]=1 with data 0xA5, held until valid drops, cleared the next edge.
- Single write: consumer 3 writes 0x5C to 0x22 -> mem_write_valid[0] pulses once with addr/data 0x22/0x5C. consumer_write_ready[3] follows the mem_write_ready pulse; a readback of 0x22 returns 0x5C.
- Oversubscription: all 8 consumers read addr i (memory i=i+1) in the same cycle -> consumers 0-3 grabbed by channels 0-3. Consumers 4-7 are served after releases. Each receives data i+1; no duplicate issues and no lost requests.
- Simultaneous read+write on one consumer: read is served first; the write is served after the read handshake completes.
- Reset mid-operation: assert rst_n=0 while channel 1 is in READ_WAIT -> all outputs 0 immediately. A late mem_read_ready after release is ignored; FSMs are IDLE.
- WRITE_ENABLE=0 instance: consumer write request -> no mem_write_valid ever; a concurrent read is still served normally.

Source files
------------

// File: rtl/gpu_mem_controller.sv
// gpu_mem_controller
//   Relays requests from NUM_CONSUMERS memory consumers onto NUM_CHANNELS
//   downstream memory channels. Each channel runs its own FSM:
//   IDLE -> READ_WAIT | WRITE_WAIT -> RELAY -> IDLE.
//   In IDLE a channel grabs the lowest-numbered unclaimed consumer with a
//   pending request (read before write). Lower channels pick first.
//   In RELAY the consumer ready is held until the consumer drops its valid
//   (four-phase handshake).
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   consumer_read_*            per-consumer read request / response
//   consumer_write_*           per-consumer write request / response
//   mem_read_*                 per-channel downstream read issue / completion
//   mem_write_*                per-channel downstream write issue / completion
//   Multi-lane buses are flattened: lane i occupies [i*W +: W].
module gpu_mem_controller #(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 8,
  parameter int NUM_CONSUMERS = 8,
  parameter int NUM_CHANNELS  = 4,
  parameter int WRITE_ENABLE  = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_CONSUMERS-1:0]             consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_WIDTH-1:0]  consumer_read_addr,
  output logic [NUM_CONSUMERS-1:0]             consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_WIDTH-1:0]  consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]             consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_WIDTH-1:0]  consumer_write_addr,
  input  logic [NUM_CONSUMERS*DATA_WIDTH-1:0]  consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]             consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]              mem_read_valid,
  output logic [NUM_CHANNELS*ADDR_WIDTH-1:0]   mem_read_addr,
  input  logic [NUM_CHANNELS-1:0]              mem_read_ready,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]   mem_read_data,
  output logic [NUM_CHANNELS-1:0]              mem_write_valid,
  output logic [NUM_CHANNELS*ADDR_WIDTH-1:0]   mem_write_addr,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0]   mem_write_data,
  input  logic [NUM_CHANNELS-1:0]              mem_write_ready
);

  localparam int OWN_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_READ_WAIT  = 2'd1,
    ST_WRITE_WAIT = 2'd2,
    ST_RELAY      = 2'd3
  } chan_state_e;

  chan_state_e                 state_r     [NUM_CHANNELS];
  logic [OWN_W-1:0]            owner_r     [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]     is_read_r;
  logic [NUM_CONSUMERS-1:0]    claimed_r;

  logic [NUM_CONSUMERS-1:0]    write_req_s;
  logic [NUM_CHANNELS-1:0]     grant_s;
  logic [NUM_CHANNELS-1:0]     grant_read_s;
  logic [OWN_W-1:0]            grant_idx_s [NUM_CHANNELS];

  // Write requests are invisible when the instance has no write path.
  always_comb begin
    if (WRITE_ENABLE != 0) begin
      write_req_s = consumer_write_valid;
    end else begin
      write_req_s = '0;
    end
  end

  // Grab selection: channel 0 picks first and the mask it extends is what
  // channel 1 sees, so no two channels can pick the same consumer.
  always_comb begin
    logic [NUM_CONSUMERS-1:0] claim_v;
    claim_v      = claimed_r;
    grant_s      = '0;
    grant_read_s = '0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      grant_idx_s[ch] = '0;
      if (state_r[ch] == ST_IDLE) begin
        for (int c = 0; c < NUM_CONSUMERS; c++) begin
          if (!grant_s[ch] && !claim_v[c] && (consumer_read_valid[c] || write_req_s[c])) begin
            grant_s[ch]      = 1'b1;
            grant_read_s[ch] = consumer_read_valid[c];
            grant_idx_s[ch]  = OWN_W'(c);
            claim_v[c]       = 1'b1;
          end else begin
            claim_v[c] = claim_v[c];
          end
        end
      end else begin
        grant_s[ch] = 1'b0;
      end
    end
  end

  // Channel FSMs, claim mask and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        state_r[ch] <= ST_IDLE;
        owner_r[ch] <= '0;
      end
      is_read_r            <= '0;
      claimed_r            <= '0;
      consumer_read_ready  <= '0;
      consumer_read_data   <= '0;
      consumer_write_ready <= '0;
      mem_read_valid       <= '0;
      mem_read_addr        <= '0;
      mem_write_valid      <= '0;
      mem_write_addr       <= '0;
      mem_write_data       <= '0;
    end else begin
      // Issue strobes are single-cycle pulses.
      mem_read_valid  <= '0;
      mem_write_valid <= '0;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        case (state_r[ch])
          ST_IDLE: begin
            if (grant_s[ch]) begin
              claimed_r[grant_idx_s[ch]] <= 1'b1;
              owner_r[ch]                <= grant_idx_s[ch];
              is_read_r[ch]              <= grant_read_s[ch];
              if (grant_read_s[ch]) begin
                mem_read_valid[ch] <= 1'b1;
                mem_read_addr[ch*ADDR_WIDTH +: ADDR_WIDTH] <=
                  consumer_read_addr[grant_idx_s[ch]*ADDR_WIDTH +: ADDR_WIDTH];
                state_r[ch] <= ST_READ_WAIT;
              end else begin
                mem_write_valid[ch] <= 1'b1;
                mem_write_addr[ch*ADDR_WIDTH +: ADDR_WIDTH] <=
                  consumer_write_addr[grant_idx_s[ch]*ADDR_WIDTH +: ADDR_WIDTH];
                mem_write_data[ch*DATA_WIDTH +: DATA_WIDTH] <=
                  consumer_write_data[grant_idx_s[ch]*DATA_WIDTH +: DATA_WIDTH];
                state_r[ch] <= ST_WRITE_WAIT;
              end
            end
          end
          ST_READ_WAIT: begin
            if (mem_read_ready[ch]) begin
              consumer_read_data[owner_r[ch]*DATA_WIDTH +: DATA_WIDTH] <=
                mem_read_data[ch*DATA_WIDTH +: DATA_WIDTH];
              consumer_read_ready[owner_r[ch]] <= 1'b1;
              state_r[ch] <= ST_RELAY;
            end
          end
          ST_WRITE_WAIT: begin
            if (mem_write_ready[ch]) begin
              consumer_write_ready[owner_r[ch]] <= 1'b1;
              state_r[ch] <= ST_RELAY;
            end
          end
          ST_RELAY: begin
            // Release only once the owner has withdrawn the request it was served for.
            if (is_read_r[ch]) begin
              if (!consumer_read_valid[owner_r[ch]]) begin
                consumer_read_ready[owner_r[ch]] <= 1'b0;
                claimed_r[owner_r[ch]]           <= 1'b0;
                state_r[ch]                      <= ST_IDLE;
              end
            end else begin
              if (!consumer_write_valid[owner_r[ch]]) begin
                consumer_write_ready[owner_r[ch]] <= 1'b0;
                claimed_r[owner_r[ch]]            <= 1'b0;
                state_r[ch]                       <= ST_IDLE;
              end
            end
          end
          default: begin
            state_r[ch] <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gpu_mem_controller.sv
module tb_gpu_mem_controller;

  localparam int NC        = 8;
  localparam int NCH       = 4;
  localparam int OP_BUDGET = 300;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // data-memory instance
  logic [NC-1:0]    rv, crr, wv, cwr;
  logic [NC*8-1:0]  ra, crd, wa, wd;
  logic [NCH-1:0]   mrv, mrr, mwv, mwr;
  logic [NCH*8-1:0] mra, mrd, mwa, mwd;

  // read-only instance
  logic [NC-1:0]    ro_rv, ro_crr, ro_wv, ro_cwr;
  logic [NC*8-1:0]  ro_ra, ro_crd, ro_wa, ro_wd;
  logic [NCH-1:0]   ro_mrv, ro_mrr, ro_mwv, ro_mwr;
  logic [NCH*8-1:0] ro_mra, ro_mrd, ro_mwa, ro_mwd;

  gpu_mem_controller #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .NUM_CONSUMERS(NC),
                       .NUM_CHANNELS(NCH), .WRITE_ENABLE(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .consumer_read_valid(rv), .consumer_read_addr(ra),
    .consumer_read_ready(crr), .consumer_read_data(crd),
    .consumer_write_valid(wv), .consumer_write_addr(wa),
    .consumer_write_data(wd), .consumer_write_ready(cwr),
    .mem_read_valid(mrv), .mem_read_addr(mra),
    .mem_read_ready(mrr), .mem_read_data(mrd),
    .mem_write_valid(mwv), .mem_write_addr(mwa),
    .mem_write_data(mwd), .mem_write_ready(mwr)
  );

  gpu_mem_controller #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .NUM_CONSUMERS(NC),
                       .NUM_CHANNELS(NCH), .WRITE_ENABLE(0)) dut_ro (
    .clk(clk), .rst_n(rst_n),
    .consumer_read_valid(ro_rv), .consumer_read_addr(ro_ra),
    .consumer_read_ready(ro_crr), .consumer_read_data(ro_crd),
    .consumer_write_valid(ro_wv), .consumer_write_addr(ro_wa),
    .consumer_write_data(ro_wd), .consumer_write_ready(ro_cwr),
    .mem_read_valid(ro_mrv), .mem_read_addr(ro_mra),
    .mem_read_ready(ro_mrr), .mem_read_data(ro_mrd),
    .mem_write_valid(ro_mwv), .mem_write_addr(ro_mwa),
    .mem_write_data(ro_mwd), .mem_write_ready(ro_mwr)
  );

  int total = 0;
  int bad   = 0;

  // external memory seen by the channels, and the consumers' expected view
  logic [7:0] ext_mem [256];
  logic [7:0] ref_mem [256];

  // responder state per channel
  int         rcnt [NCH];
  int         wcnt [NCH];
  logic [7:0] raddr [NCH];
  int         fixed_lat = 2;
  bit         unsol_en  = 1'b0;

  // consumer agent state: 0 idle, 1 waiting for ready, 2 checking release
  int         rs [NC];
  int         ws [NC];
  int         rwt [NC];
  int         wwt [NC];
  logic [7:0] rd_exp [NC];
  logic [7:0] wr_addr [NC];
  logic [7:0] wr_dat [NC];
  bit         both [NC];

  int n_rd_issue = 0, n_wr_issue = 0, n_rd_done = 0, n_wr_done = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick_lat();
    if (fixed_lat != 0) return fixed_lat;
    else return int'($urandom_range(1, 3));
  endfunction

  // Advance to the next falling edge and run the memory model.
  task automatic tick();
    @(negedge clk);
    mrr = '0;
    mwr = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      if (rcnt[ch] > 0) begin
        rcnt[ch]--;
        if (rcnt[ch] == 0) begin
          mrr[ch] = 1'b1;
          mrd[ch*8 +: 8] = ext_mem[raddr[ch]];
        end
      end else if (unsol_en && !mrv[ch] && $urandom_range(0, 19) == 0) begin
        mrr[ch] = 1'b1;
        mrd[ch*8 +: 8] = 8'hEE;
      end
      if (wcnt[ch] > 0) begin
        wcnt[ch]--;
        if (wcnt[ch] == 0) mwr[ch] = 1'b1;
      end else if (unsol_en && !mwv[ch] && $urandom_range(0, 19) == 0) begin
        mwr[ch] = 1'b1;
      end
      if (mrv[ch]) begin
        check_eq("rd_reissue", rcnt[ch], 0);
        n_rd_issue++;
        raddr[ch] = mra[ch*8 +: 8];
        rcnt[ch]  = pick_lat();
      end
      if (mwv[ch]) begin
        check_eq("wr_reissue", wcnt[ch], 0);
        n_wr_issue++;
        ext_mem[mwa[ch*8 +: 8]] = mwd[ch*8 +: 8];
        wcnt[ch] = pick_lat();
      end
    end
  endtask

  task automatic start_read(input int c, input logic [7:0] addr, input logic [7:0] exp);
    rv[c] = 1'b1;
    ra[c*8 +: 8] = addr;
    rd_exp[c] = exp;
    rs[c] = 1;
    rwt[c] = 0;
    both[c] = 1'b0;
  endtask

  task automatic start_write(input int c, input logic [7:0] addr, input logic [7:0] data);
    wv[c] = 1'b1;
    wa[c*8 +: 8] = addr;
    wd[c*8 +: 8] = data;
    wr_addr[c] = addr;
    wr_dat[c] = data;
    ws[c] = 1;
    wwt[c] = 0;
  endtask

  function automatic logic [NC-1:0] busy_mask();
    logic [NC-1:0] m;
    for (int c = 0; c < NC; c++) m[c] = (rs[c] != 0) || (ws[c] != 0);
    return m;
  endfunction

  // Consumer side: check responses, complete handshakes, optionally start new work.
  task automatic agents_step(input bit gen);
    logic [NC-1:0] rd_win, wr_win;
    logic [2:0]    cb;
    int            kind;
    logic [7:0]    addr;
    for (int c = 0; c < NC; c++) begin
      rd_win[c] = (rs[c] == 1);
      wr_win[c] = (ws[c] == 1);
    end
    check_eq("rd_spurious", crr & ~rd_win, '0);
    check_eq("wr_spurious", cwr & ~wr_win, '0);
    for (int c = 0; c < NC; c++) begin
      if (rs[c] == 1) begin
        if (crr[c]) begin
          check_eq("rd_data", crd[c*8 +: 8], rd_exp[c]);
          rv[c] = 1'b0; rs[c] = 2; n_rd_done++;
        end else begin
          rwt[c]++;
          if (rwt[c] > OP_BUDGET) begin
            check_eq("rd_timeout", crr[c], 1'b1);
            rv[c] = 1'b0; rs[c] = 0;
          end
        end
      end else if (rs[c] == 2) begin
        check_eq("rd_release", crr[c], 1'b0);
        rs[c] = 0;
      end
      if (ws[c] == 1) begin
        if (cwr[c]) begin
          if (both[c]) check_eq("rw_order", rs[c], 0);
          ref_mem[wr_addr[c]] = wr_dat[c];
          wv[c] = 1'b0; ws[c] = 2; n_wr_done++;
        end else begin
          wwt[c]++;
          if (wwt[c] > OP_BUDGET) begin
            check_eq("wr_timeout", cwr[c], 1'b1);
            wv[c] = 1'b0; ws[c] = 0;
          end
        end
      end else if (ws[c] == 2) begin
        check_eq("wr_release", cwr[c], 1'b0);
        ws[c] = 0;
      end
      if (gen && rs[c] == 0 && ws[c] == 0 && $urandom_range(0, 3) == 0) begin
        cb   = 3'(c);
        kind = int'($urandom_range(0, 2));
        if (kind != 1) begin
          addr = {cb, 5'($urandom_range(0, 31))};
          start_read(c, addr, ref_mem[addr]);
        end
        if (kind != 0) start_write(c, {cb, 5'($urandom_range(0, 31))}, 8'($urandom));
        both[c] = (kind == 2);
      end
    end
  endtask

  task automatic run_until_idle(input int budget);
    int k;
    k = 0;
    while (busy_mask() != '0 && k < budget) begin
      tick();
      agents_step(1'b0);
      k++;
    end
    check_eq("drain", busy_mask(), '0);
  endtask

  task automatic clear_bench();
    rv = '0; ra = '0; wv = '0; wa = '0; wd = '0;
    mrr = '0; mrd = '0; mwr = '0;
    for (int c = 0; c < NC; c++) begin
      rs[c] = 0; ws[c] = 0; rwt[c] = 0; wwt[c] = 0; both[c] = 1'b0;
    end
    for (int ch = 0; ch < NCH; ch++) begin
      rcnt[ch] = 0; wcnt[ch] = 0; raddr[ch] = '0;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq(tag, {crr, cwr, mrv, mwv}, '0);
    check_eq(tag, crd, '0);
    check_eq(tag, mra, '0);
    check_eq(tag, {mwa, mwd}, '0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int         s_ri, s_rd, s_wi, s_wd, k;
    bit         seen;
    logic [7:0] v;
    bit         ro_got, ro_bad_w, ro_bad_cw;

    for (int a = 0; a < 256; a++) begin
      v = 8'($urandom);
      ext_mem[a] = v;
      ref_mem[a] = v;
    end
    clear_bench();
    ro_rv = '0; ro_ra = '0; ro_wv = '0; ro_wa = '0; ro_wd = '0;
    ro_mrr = '0; ro_mrd = '0; ro_mwr = '0;

    // reset state
    repeat (2) @(negedge clk);
    check_outputs_zero("reset_in");
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs_zero("reset_out");

    // single read, latency 2, with hold and release
    fixed_lat = 2;
    ext_mem[8'h10] = 8'hA5; ref_mem[8'h10] = 8'hA5;
    rv[0] = 1'b1; ra[7:0] = 8'h10;
    tick();
    check_eq("sr_issue", mrv, 4'b0001);
    check_eq("sr_addr", mra[7:0], 8'h10);
    tick();
    check_eq("sr_no_reissue", mrv, 4'b0000);
    tick();
    check_eq("sr_not_early", crr, '0);
    tick();
    check_eq("sr_ready", crr, 8'h01);
    check_eq("sr_data", crd[7:0], 8'hA5);
    tick();
    check_eq("sr_hold", crr, 8'h01);
    check_eq("sr_hold_data", crd[7:0], 8'hA5);
    rv[0] = 1'b0;
    tick();
    check_eq("sr_clear", crr, '0);

    // single write from consumer 3, then readback
    wv[3] = 1'b1; wa[31:24] = 8'h22; wd[31:24] = 8'h5C;
    tick();
    check_eq("sw_issue", mwv, 4'b0001);
    check_eq("sw_addr", mwa[7:0], 8'h22);
    check_eq("sw_data", mwd[7:0], 8'h5C);
    s_wi = n_wr_issue;
    seen = 1'b0;
    k = 0;
    while (!seen && k < 20) begin
      tick();
      seen = cwr[3];
      k++;
    end
    check_eq("sw_ready", cwr, 8'h08);
    check_eq("sw_single_issue", n_wr_issue - s_wi, 0);
    wv[3] = 1'b0;
    tick();
    check_eq("sw_clear", cwr, '0);
    ref_mem[8'h22] = 8'h5C;
    start_read(3, 8'h22, 8'h5C);
    run_until_idle(100);

    // oversubscription: eight reads at once
    for (int i = 0; i < NC; i++) begin
      ext_mem[i] = 8'(i + 1);
      ref_mem[i] = 8'(i + 1);
    end
    s_ri = n_rd_issue; s_rd = n_rd_done;
    for (int i = 0; i < NC; i++) start_read(i, 8'(i), 8'(i + 1));
    tick();
    check_eq("os_grab", mrv, 4'b1111);
    check_eq("os_addr", mra, {8'd3, 8'd2, 8'd1, 8'd0});
    agents_step(1'b0);
    run_until_idle(200);
    check_eq("os_issues", n_rd_issue - s_ri, 8);
    check_eq("os_done", n_rd_done - s_rd, 8);

    // simultaneous read and write on consumer 5
    start_read(5, 8'hA0, ref_mem[8'hA0]);
    start_write(5, 8'hA1, 8'h77);
    both[5] = 1'b1;
    tick();
    check_eq("rw_read_first", {mrv, mwv}, {4'b0001, 4'b0000});
    agents_step(1'b0);
    run_until_idle(100);
    start_read(5, 8'hA1, 8'h77);
    run_until_idle(100);

    // reset while channel 1 is waiting on memory
    fixed_lat = 50;
    start_read(0, 8'h05, ref_mem[8'h05]);
    start_read(1, 8'h33, ref_mem[8'h33]);
    tick();
    check_eq("rst_pre_issue", mrv, 4'b0011);
    tick();
    check_eq("rst_pre_addr", mra[15:8], 8'h33);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("rst_async");
    clear_bench();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mrr = 4'b0010; mrd[15:8] = 8'h99;
    @(negedge clk);
    mrr = '0;
    check_eq("rst_late_ignored", {crr, mrv}, '0);
    @(negedge clk);
    check_eq("rst_still_quiet", {crr, cwr}, '0);
    fixed_lat = 2;
    start_read(2, 8'h45, ref_mem[8'h45]);
    start_read(3, 8'h66, ref_mem[8'h66]);
    tick();
    check_eq("rst_idle", mrv, 4'b0011);
    agents_step(1'b0);
    run_until_idle(100);

    // randomized traffic
    fixed_lat = 0;
    unsol_en  = 1'b1;
    s_ri = n_rd_issue; s_rd = n_rd_done; s_wi = n_wr_issue; s_wd = n_wr_done;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      agents_step(1'b1);
    end
    run_until_idle(600);
    unsol_en = 1'b0;
    check_eq("rand_rd_issues", n_rd_issue - s_ri, n_rd_done - s_rd);
    check_eq("rand_wr_issues", n_wr_issue - s_wi, n_wr_done - s_wd);
    check_eq("rand_activity", ((n_rd_done - s_rd) > 50) && ((n_wr_done - s_wd) > 50), 1'b1);

    // read-only instance: writes never granted, reads still served
    ro_got = 1'b0; ro_bad_w = 1'b0; ro_bad_cw = 1'b0;
    ro_wv[2] = 1'b1; ro_wa[23:16] = 8'h12; ro_wd[23:16] = 8'h34;
    ro_rv[2] = 1'b1; ro_ra[23:16] = 8'h5A;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      ro_mrr = ro_mrv;
      for (int ch = 0; ch < NCH; ch++) ro_mrd[ch*8 +: 8] = ro_mra[ch*8 +: 8] ^ 8'h3C;
      ro_mwr = 4'b1111;
      if ((ro_mwv != '0) || (ro_mwa != '0) || (ro_mwd != '0)) ro_bad_w = 1'b1;
      if (ro_cwr != '0) ro_bad_cw = 1'b1;
      if (ro_crr[2] && !ro_got) begin
        ro_got = 1'b1;
        check_eq("ro_read_data", ro_crd[23:16], 8'h66);
        ro_rv[2] = 1'b0;
      end
    end
    check_eq("ro_read_served", ro_got, 1'b1);
    check_eq("ro_no_mem_write", ro_bad_w, 1'b0);
    check_eq("ro_no_write_ready", ro_bad_cw, 1'b0);
    check_eq("ro_read_released", ro_crr, '0);
    ro_wv = '0; ro_mrr = '0; ro_mwr = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
